// File: rtl/ysyx_l1i_bus_bridge.sv
// ysyx_l1i_bus_bridge
//   Slave end of the L1I refill bus. Each accepted refill request becomes one
//   AXI4 read burst of 2**L1I_LINE_LEN beats on the instruction master port.
//   Beats are returned to L1I one word per cycle, registered (latency 1),
//   with l1i_rlast on the final beat. Read-only, one request in flight.
//
// Configuration macro: YSYX_L1I_BRIDGE_WRAP_EN
//   defined   : critical-word-first, word-aligned address, WRAP burst
//   undefined : line-aligned address, INCR burst, word 0 first
//
// Ports
//   clock, reset                 core clock, synchronous active-high reset
//   l1i_arvalid/l1i_araddr       refill request from L1I (held until l1i_rready)
//   l1i_rready                   1-cycle accept pulse
//   l1i_rdata/rvalid/rlast       returned line words
//   io_master_ar*                AXI4 read-address channel
//   io_master_r*                 AXI4 read-data channel
//   bus_err                      sticky: bad rresp, rlast mismatch, or stray rvalid
//
// States
//   S_IDLE | waiting for an L1I request
//   S_AR   | AXI address phase, arvalid held until arready
//   S_R    | collecting beats, rready held high
module ysyx_l1i_bus_bridge #(
  parameter int         XLEN         = 32,
  parameter int         L1I_LINE_LEN = 2,
  parameter logic [3:0] AXI_ID       = 4'd0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            l1i_arvalid,
  input  logic [XLEN-1:0] l1i_araddr,
  output logic            l1i_rready,
  output logic [XLEN-1:0] l1i_rdata,
  output logic            l1i_rvalid,
  output logic            l1i_rlast,
  output logic            io_master_arvalid,
  input  logic            io_master_arready,
  output logic [XLEN-1:0] io_master_araddr,
  output logic [3:0]      io_master_arid,
  output logic [7:0]      io_master_arlen,
  output logic [2:0]      io_master_arsize,
  output logic [1:0]      io_master_arburst,
  input  logic            io_master_rvalid,
  output logic            io_master_rready,
  input  logic [XLEN-1:0] io_master_rdata,
  input  logic [1:0]      io_master_rresp,
  input  logic            io_master_rlast,
  output logic            bus_err
);

  localparam int OFF = $clog2(XLEN / 8);
  localparam int CW  = L1I_LINE_LEN + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'((1 << L1I_LINE_LEN) - 1);

`ifdef YSYX_L1I_BRIDGE_WRAP_EN
  localparam int         ALIGN = OFF;
  localparam logic [1:0] BURST = 2'b10;
`else
  localparam int         ALIGN = L1I_LINE_LEN + OFF;
  localparam logic [1:0] BURST = 2'b01;
`endif
  localparam logic [XLEN-1:0] ADDR_MASK = ~((XLEN'(1) << ALIGN) - XLEN'(1));

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            acc_q, acc_d;
  logic            ar_valid_q, ar_valid_d;
  logic            r_ready_q, r_ready_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            rlast_q, rlast_d;
  logic            err_q, err_d;
  logic            is_last;

  assign is_last = (cnt_q == LAST_BEAT);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    acc_d      = 1'b0;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    rlast_d    = 1'b0;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (l1i_arvalid) begin
          addr_d     = l1i_araddr & ADDR_MASK;
          acc_d      = 1'b1;
          ar_valid_d = 1'b1;
          state_d    = S_AR;
        end
      end
      S_AR: begin
        // ar_valid_q is always high here, so arready alone completes the handshake
        if (io_master_arready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          cnt_d      = '0;
          state_d    = S_R;
        end
      end
      S_R: begin
        if (io_master_rvalid) begin
          rdata_d  = io_master_rdata;
          rvalid_d = 1'b1;
          rlast_d  = is_last;
          cnt_d    = cnt_q + CW'(1);
          // sequencing follows our own beat count; slave rlast is only cross-checked
          if ((io_master_rresp != 2'b00) || (io_master_rlast != is_last))
            err_d = 1'b1;
          if (is_last) begin
            r_ready_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (io_master_rvalid && (state_q != S_R))
      err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      acc_q      <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      acc_q      <= acc_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      err_q      <= err_d;
    end
  end

  assign l1i_rready        = acc_q;
  assign l1i_rdata         = rdata_q;
  assign l1i_rvalid        = rvalid_q;
  assign l1i_rlast         = rlast_q;
  assign io_master_arvalid = ar_valid_q;
  assign io_master_araddr  = addr_q;
  assign io_master_arid    = AXI_ID;
  assign io_master_arlen   = 8'((1 << L1I_LINE_LEN) - 1);
  assign io_master_arsize  = 3'(OFF);
  assign io_master_arburst = BURST;
  assign io_master_rready  = r_ready_q;
  assign bus_err           = err_q;

endmodule

// File: tb/tb_ysyx_l1i_bus_bridge.sv
module tb_ysyx_l1i_bus_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        l1i_arvalid;
  logic [31:0] l1i_araddr;
  logic        l1i_rready;
  logic [31:0] l1i_rdata;
  logic        l1i_rvalid;
  logic        l1i_rlast;
  logic        io_master_arvalid;
  logic        io_master_arready;
  logic [31:0] io_master_araddr;
  logic [3:0]  io_master_arid;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;
  logic        io_master_rvalid;
  logic        io_master_rready;
  logic [31:0] io_master_rdata;
  logic [1:0]  io_master_rresp;
  logic        io_master_rlast;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];
  bit model_err;

  always #5 clock = ~clock;

  ysyx_l1i_bus_bridge dut (
    .clock(clock), .reset(reset),
    .l1i_arvalid(l1i_arvalid), .l1i_araddr(l1i_araddr), .l1i_rready(l1i_rready),
    .l1i_rdata(l1i_rdata), .l1i_rvalid(l1i_rvalid), .l1i_rlast(l1i_rlast),
    .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
    .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst), .io_master_rvalid(io_master_rvalid),
    .io_master_rready(io_master_rready), .io_master_rdata(io_master_rdata),
    .io_master_rresp(io_master_rresp), .io_master_rlast(io_master_rlast),
    .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_l1i_rready"}, l1i_rready, 0);
    chk({tag, "_l1i_rvalid"}, l1i_rvalid, 0);
    chk({tag, "_l1i_rlast"}, l1i_rlast, 0);
    chk({tag, "_l1i_rdata"}, l1i_rdata, 0);
    chk({tag, "_arvalid"}, io_master_arvalid, 0);
    chk({tag, "_m_rready"}, io_master_rready, 0);
    chk({tag, "_bus_err"}, bus_err, 0);
  endtask

  // Line words are returned to L1I in arrival order; the reference only
  // cares that the k-th beat delivered equals the k-th beat the slave sent.
  always @(negedge clock) begin
    if (reset === 1'b0 && l1i_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 1, 0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rdata", l1i_rdata, e[31:0]);
        chk("rlast", l1i_rlast, e[32]);
      end
    end
  end

  task automatic refill(input logic [31:0] addr, input int ar_dly, input int gap,
                        input bit seq_data, input int err_beat, input int badlast_beat,
                        input int abort_after);
    logic [31:0] exp_addr;
    logic [1:0]  exp_burst;
    logic [31:0] d;
    int waited;
    int g;
`ifdef YSYX_L1I_BRIDGE_WRAP_EN
    exp_addr  = {addr[31:2], 2'b00};
    exp_burst = 2'b10;
`else
    exp_addr  = {addr[31:4], 4'b0000};
    exp_burst = 2'b01;
`endif
    l1i_arvalid = 1'b1;
    l1i_araddr  = addr;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (l1i_rready !== 1'b1 && waited < 10);
    chk("accept", l1i_rready, 1);
    l1i_arvalid = 1'b0;
    l1i_araddr  = $urandom;
    if (l1i_rready !== 1'b1) return;
    chk("arvalid", io_master_arvalid, 1);
    chk("araddr", io_master_araddr, exp_addr);
    chk("arlen", io_master_arlen, 3);
    chk("arsize", io_master_arsize, 2);
    chk("arburst", io_master_arburst, exp_burst);
    chk("arid", io_master_arid, 0);
    for (int i = 0; i < ar_dly; i++) begin
      tick();
      chk("ar_hold", io_master_arvalid, 1);
      chk("araddr_stable", io_master_araddr, exp_addr);
      chk("rready_pulse", l1i_rready, 0);
    end
    io_master_arready = 1'b1;
    tick();
    io_master_arready = 1'b0;
    chk("ar_done", io_master_arvalid, 0);
    chk("m_rready", io_master_rready, 1);
    chk("rready_low", l1i_rready, 0);
    for (int b = 0; b < 4; b++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) tick();
      d = seq_data ? 32'(17 * (b + 1)) : $urandom;
      io_master_rvalid = 1'b1;
      io_master_rdata  = d;
      io_master_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
      io_master_rlast  = (b == 3) ^ (b == badlast_beat);
      exp_q.push_back({(b == 3), d});
      if (b == err_beat || b == badlast_beat) model_err = 1'b1;
      tick();
      io_master_rvalid = 1'b0;
      io_master_rresp  = 2'b00;
      io_master_rlast  = 1'b0;
      if (b == abort_after) begin
        tick();
        reset = 1'b1;
        tick();
        chk_all_zero("abort");
        chk("abort_drained", exp_q.size(), 0);
        reset = 1'b0;
        model_err = 1'b0;
        exp_q.delete();
        return;
      end
    end
    tick();
    chk("drained", exp_q.size(), 0);
    chk("bus_err", bus_err, model_err);
    chk("back_idle", io_master_rready, 0);
  endtask

  initial begin
    reset = 1'b1;
    l1i_arvalid = 1'b1;
    l1i_araddr  = 32'h8000_0008;
    io_master_arready = 1'b0;
    io_master_rvalid  = 1'b0;
    io_master_rdata   = '0;
    io_master_rresp   = 2'b00;
    io_master_rlast   = 1'b0;
    model_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all_zero("reset");
    end
    l1i_arvalid = 1'b0;
    reset = 1'b0;
    tick();

    refill(32'h8000_0008, 0, 0, 1'b1, -1, -1, -1);
    refill(32'h8000_1234, 5, 2, 1'b0, -1, -1, -1);
    refill(32'h8000_0040, 0, 1, 1'b0, 2, -1, -1);
    refill(32'h8000_0080, 1, 0, 1'b0, -1, -1, -1);
    chk("err_sticky", bus_err, 1);
    refill(32'h8000_00C4, 2, 0, 1'b0, -1, -1, 1);
    refill(32'h8000_0010, 0, 0, 1'b0, -1, -1, -1);
    chk("after_abort_err", bus_err, 0);

    for (int i = 0; i < 30; i++) begin
      int eb, lb;
      if (i % 8 == 7) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_err = 1'b0;
        chk("rand_reset_err", bus_err, 0);
      end
      eb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      lb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      refill({$urandom} & 32'hFFFF_FFFC, int'($urandom_range(0, 4)), -1, 1'b0, eb, lb, -1);
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
